// File: rtl/mandelbrot_engine_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mandelbrot_engine_param
// Purpose  : Parametrised Mandelbrot / Julia escape-time iterator. Operands
//            are shifted in a byte at a time into shadow registers, so the
//            host can stage the next point while the current one iterates.
//            One iteration is performed per clock. A start/busy/result-valid
//            handshake runs each point, with a runtime iteration limit and
//            an abort.
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_ld_valid   byte load strobe
//   i_ld_sel     target shadow: 0=Cr, 1=Ci, 2=Zr, 3=Zi
//   i_ld_byte    load data byte (first byte sent lands in the LSB)
//   i_julia      sampled at start: 1 = Z0 from Zr/Zi shadows, 0 = Z0 = C
//   i_max_iter   iteration limit, sampled at start
//   i_start      start request (ignored while running)
//   i_abort      cancel the current run (ignored outside RUN)
//   o_busy       high while iterating
//   o_res_valid  result available, held until consumed or restarted
//   i_res_ready  result consume
//   o_escaped    1 = point escaped, 0 = hit the iteration limit
//   o_iter       iteration count of the result
// ============================================================================
module mandelbrot_engine_param #(
  parameter int WIDTH  = 32,  // operand width, multiple of 8, >= 16
  parameter int FRAC   = 28,  // fractional bits of the signed fixed-point format
  parameter int ITER_W = 8    // iteration counter / limit width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_valid,
  input  logic [1:0]        i_ld_sel,
  input  logic [7:0]        i_ld_byte,
  input  logic              i_julia,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_escaped,
  output logic [ITER_W-1:0] o_iter
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Shadow register indices
  localparam logic [1:0] c_SEL_CR = 2'd0;
  localparam logic [1:0] c_SEL_CI = 2'd1;
  localparam logic [1:0] c_SEL_ZR = 2'd2;
  localparam logic [1:0] c_SEL_ZI = 2'd3;

  // Escape threshold |Z|^2 > 4.0, i.e. 2^(2*FRAC+2) in the squared scale.
  // The magnitude is kept two bits wider than a product so the sum of two
  // squares can never overflow.
  localparam int c_MAG_W = 2 * WIDTH + 2;
  localparam logic [c_MAG_W-1:0] c_esc_lim =
    {{(c_MAG_W - 2 * FRAC - 3){1'b0}}, 1'b1, {(2 * FRAC + 2){1'b0}}};

  state_t                   r_state;
  logic        [WIDTH-1:0]  r_shadow [4];
  logic signed [WIDTH-1:0]  r_cr;
  logic signed [WIDTH-1:0]  r_ci;
  logic signed [WIDTH-1:0]  r_zr;
  logic signed [WIDTH-1:0]  r_zi;
  logic        [ITER_W-1:0] r_lim;
  logic        [ITER_W-1:0] r_cnt;
  logic                     r_busy;
  logic                     r_res_valid;
  logic                     r_escaped;
  logic        [ITER_W-1:0] r_iter;

  // --------------------------------------------------------------------------
  // Datapath: full-precision products of the registered Z
  // --------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] w_zr_ext;
  logic signed [2*WIDTH-1:0] w_zi_ext;
  logic signed [2*WIDTH-1:0] w_zr_sq;
  logic signed [2*WIDTH-1:0] w_zi_sq;
  logic signed [2*WIDTH-1:0] w_zr_zi;
  logic        [c_MAG_W-1:0] w_mag;
  logic                      w_esc;
  logic signed [2*WIDTH-1:0] w_diff;
  logic signed [2*WIDTH:0]   w_cross;
  logic signed [WIDTH-1:0]   w_zr_nxt;
  logic signed [WIDTH-1:0]   w_zi_nxt;

  // Sign-extend before multiplying so the products are exact at 2*WIDTH bits
  assign w_zr_ext = {{WIDTH{r_zr[WIDTH-1]}}, r_zr};
  assign w_zi_ext = {{WIDTH{r_zi[WIDTH-1]}}, r_zi};
  assign w_zr_sq  = w_zr_ext * w_zr_ext;
  assign w_zi_sq  = w_zi_ext * w_zi_ext;
  assign w_zr_zi  = w_zr_ext * w_zi_ext;

  // Squares are non-negative, so zero-extension is exact for the sum
  assign w_mag = {2'b00, w_zr_sq} + {2'b00, w_zi_sq};
  assign w_esc = (w_mag > c_esc_lim);

  // Difference of squares fits 2*WIDTH bits; 2*Zr*Zi needs one extra bit
  // (both operands at the most negative value).
  assign w_diff  = w_zr_sq - w_zi_sq;
  assign w_cross = {w_zr_zi, 1'b0};

  // Arithmetic shift floors; truncating to WIDTH gives wrap-around sums
  assign w_zr_nxt = WIDTH'(w_diff  >>> FRAC) + r_cr;
  assign w_zi_nxt = WIDTH'(w_cross >>> FRAC) + r_ci;

  // --------------------------------------------------------------------------
  // Control FSM, shadow loading and working registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
      end
      r_cr        <= '0;
      r_ci        <= '0;
      r_zr        <= '0;
      r_zi        <= '0;
      r_lim       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_escaped   <= 1'b0;
      r_iter      <= '0;
    end else begin
      // Byte-serial shift-in, legal in every state. A start on the same edge
      // reads the old shadow contents because of non-blocking semantics.
      if (i_ld_valid) begin
        r_shadow[i_ld_sel] <= {i_ld_byte, r_shadow[i_ld_sel][WIDTH-1:8]};
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_cr        <= r_shadow[c_SEL_CR];
            r_ci        <= r_shadow[c_SEL_CI];
            r_zr        <= i_julia ? r_shadow[c_SEL_ZR] : r_shadow[c_SEL_CR];
            r_zi        <= i_julia ? r_shadow[c_SEL_ZI] : r_shadow[c_SEL_CI];
            r_lim       <= i_max_iter;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_res_valid <= 1'b0;
            r_escaped   <= 1'b0;
            r_state     <= S_RUN;
          end else if ((r_state == S_DONE) && i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_esc) begin
            r_busy      <= 1'b0;
            r_res_valid <= 1'b1;
            r_escaped   <= 1'b1;
            r_iter      <= r_cnt;
            r_state     <= S_DONE;
          end else if (r_cnt == r_lim) begin
            r_busy      <= 1'b0;
            r_res_valid <= 1'b1;
            r_escaped   <= 1'b0;
            r_iter      <= r_cnt;
            r_state     <= S_DONE;
          end else begin
            r_zr  <= w_zr_nxt;
            r_zi  <= w_zi_nxt;
            // Cannot wrap: the limit check above stops at r_lim <= max count
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_escaped   = r_escaped;
  assign o_iter      = r_iter;

endmodule
`default_nettype wire
